// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, clocks out
// one command byte on device-generated clock edges and checks the device ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       kbdclk,
   input  logic       kbddat,
   output logic       kbdclk_low,
   output logic       kbddat_low,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE,
      ST_DONE,
      ST_ERR
   } state_e;

   state_e           state_q, state_d;
   logic [8:0]       frame_q, frame_d;     // {parity, data}, sent LSB first
   logic [3:0]       bit_q, bit_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             dat_low_q, dat_low_d;

   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic dat_meta_q, dat_sync_q;
   logic clk_fall;
   logic tmo_hit;

   // NOTE: synchronisers reset to 1, the idle level of both open-drain lines, so
   // leaving reset never looks like a device clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= kbdclk;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= kbddat;
         dat_sync_q <= dat_meta_q;
      end
   end

   assign clk_fall = clk_prev_q & ~clk_sync_q;
   assign tmo_hit  = (tmo_cnt_q == TMO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         frame_q   <= '0;
         bit_q     <= '0;
         inh_cnt_q <= '0;
         tmo_cnt_q <= '0;
         dat_low_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bit_q     <= bit_d;
         inh_cnt_q <= inh_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         dat_low_q <= dat_low_d;
      end
   end

   // NOTE: every variable gets its hold value first, so no path through the case
   // statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_d     = bit_q;
      inh_cnt_d = inh_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      dat_low_d = dat_low_q;

      unique case (state_q)
         ST_IDLE: begin
            if (tx_valid) begin
               frame_d   = {~^tx_data, tx_data};
               inh_cnt_d = '0;
               bit_d     = '0;
               dat_low_d = 1'b0;
               state_d   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               dat_low_d = 1'b1;              // start bit
               state_d   = ST_REQ;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end
         ST_REQ: begin
            tmo_cnt_d = '0;
            bit_d     = '0;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_hit) begin
               state_d = ST_ERR;
            end else if (clk_fall) begin
               if (bit_q == 4'd9) begin
                  dat_low_d = 1'b0;           // stop bit: release data
                  state_d   = ST_ACK;
               end else begin
                  dat_low_d = ~frame_q[bit_q];
                  bit_d     = bit_q + 1'b1;
               end
            end
         end
         ST_ACK: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_hit) begin
               state_d = ST_ERR;
            end else if (clk_fall) begin
               state_d = dat_sync_q ? ST_ERR : ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_hit) begin
               state_d = ST_ERR;
            end else if (clk_sync_q && dat_sync_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE, ST_ERR: begin
            dat_low_d = 1'b0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_ERR) begin
         dat_low_d = 1'b0;
      end
   end

   assign tx_ready   = (state_q == ST_IDLE) && !rst;
   assign busy       = (state_q != ST_IDLE);
   assign kbdclk_low = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
   assign kbddat_low = dat_low_q;
   assign tx_done    = (state_q == ST_DONE);
   assign tx_err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device drives the open-drain
// lines, and every captured frame is compared with one built from the byte by arithmetic.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int unsigned INH = 20;
   localparam int unsigned TMO = 500;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       kbdclk, kbddat;
   logic       kbdclk_low, kbddat_low;
   logic       busy, tx_done, tx_err;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Wired-AND bus: either side pulling low wins.
   assign kbdclk = ~(kbdclk_low | dev_clk_low);
   assign kbddat = ~(kbddat_low | dev_dat_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .kbdclk    (kbdclk),
      .kbddat    (kbddat),
      .kbdclk_low(kbdclk_low),
      .kbddat_low(kbddat_low),
      .busy      (busy),
      .tx_done   (tx_done),
      .tx_err    (tx_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Bus monitor, sampled on the falling system clock edge.
   int   cyc = 0;
   int   done_total = 0, err_total = 0, ready_viol = 0;
   int   done_cyc = 0, err_cyc = 0, rel_cyc = 0;
   int   inh_run = 0, inh_len = 0;
   logic [1:0] err_lines = 2'b00;
   logic prev_clk_low = 1'b0, prev_done = 1'b0, prev2_done = 1'b0, prev_err = 1'b0;
   logic busy_after_done = 1'b0, busy_after_done2 = 1'b0, ready_after_err = 1'b0;

   always @(negedge clk) begin
      cyc          <= cyc + 1;
      prev_clk_low <= kbdclk_low;
      prev_done    <= tx_done;
      prev2_done   <= prev_done;
      prev_err     <= tx_err;
      if (tx_done) begin
         done_total <= done_total + 1;
         done_cyc   <= cyc;
      end
      if (tx_err) begin
         err_total <= err_total + 1;
         err_cyc   <= cyc;
         err_lines <= {kbdclk_low, kbddat_low};
      end
      if (prev_clk_low && !kbdclk_low && busy) rel_cyc <= cyc;
      if (kbdclk_low && !kbddat_low) inh_run <= inh_run + 1;
      else inh_run <= 0;
      if (kbdclk_low && kbddat_low) inh_len <= inh_run;
      if (prev_done) busy_after_done <= busy;
      if (prev2_done) busy_after_done2 <= busy;
      if (prev_err) ready_after_err <= tx_ready;
      if (busy && tx_ready) ready_viol <= ready_viol + 1;
   end

   // Expected 11-bit line frame: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] exp_frame(input logic [7:0] b);
      logic [10:0] f;
      int ones;
      ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
         ones += int'(b[i]);
      end
      f[9]  = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic send_req(input logic [7:0] b);
      @(posedge clk); #1;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_ready) break;
      end
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   // Device model: waits for request-to-send, generates n_edges clock pulses,
   // reads each bit while its clock is low and optionally acknowledges on edge 11.
   task automatic device(input int n_edges, input bit ack_ok,
                         output logic [10:0] frame, output bit rts_ok);
      frame  = '0;
      rts_ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (kbdclk === 1'b1 && kbddat === 1'b0) begin
            rts_ok = 1'b1;
            break;
         end
      end
      if (!rts_ok) return;
      repeat (5) @(negedge clk);
      frame[0] = kbddat;
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11 && ack_ok) begin
            dev_dat_low = 1'b1;
            repeat (2) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         repeat (10) @(negedge clk);
         if (k <= 10) frame[k] = kbddat;
         dev_clk_low = 1'b0;
         if (k == 11) dev_dat_low = 1'b0;
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic run_xfer(input logic [7:0] b, input int n_edges, input bit ack_ok,
                           output logic [10:0] frame, output bit rts_ok);
      logic [10:0] f;
      bit r;
      fork
         send_req(b);
         device(n_edges, ack_ok, f, r);
      join
      frame  = f;
      rts_ok = r;
   endtask

   task automatic wait_end(input int bound, input int d0, input int e0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk); #1;
         if (done_total != d0 || err_total != e0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk); #1;
      n_checks++;
      if ({tx_ready, kbdclk_low, kbddat_low, busy, tx_done, tx_err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready/clk/dat/busy/done/err=%b want 000000",
                  {tx_ready, kbdclk_low, kbddat_low, busy, tx_done, tx_err});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (tx_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got ready=%b busy=%b want ready=1 busy=0", tx_ready, busy);
      end
   endtask

   task automatic test_send(input logic [7:0] b);
      logic [10:0] f;
      bit r, ok;
      int d0, e0;
      d0 = done_total;
      e0 = err_total;
      run_xfer(b, 11, 1'b1, f, r);
      wait_end(200, d0, e0, ok);
      repeat (3) @(negedge clk); #1;
      n_checks++;
      if (!r || !ok) begin
         n_fail++;
         $display("FAIL send_%h_handshake: got rts=%0d end=%0d want 1 1", b, r, ok);
      end
      n_checks++;
      if (f !== exp_frame(b)) begin
         n_fail++;
         $display("FAIL send_%h_frame: got %b want %b (stop..start)", b, f, exp_frame(b));
      end
      n_checks++;
      if (done_total - d0 !== 1 || err_total - e0 !== 0) begin
         n_fail++;
         $display("FAIL send_%h_pulses: got done=%0d err=%0d want 1 0",
                  b, done_total - d0, err_total - e0);
      end
      n_checks++;
      if (busy_after_done !== 1'b0) begin
         n_fail++;
         $display("FAIL send_%h_busy_fall: got busy=%b the cycle after done want 0",
                  b, busy_after_done);
      end
      n_checks++;
      if (inh_len !== INH) begin
         n_fail++;
         $display("FAIL send_%h_inhibit: got %0d cycles want %0d", b, inh_len, INH);
      end
   endtask

   task automatic test_nack();
      logic [10:0] f;
      bit r, ok;
      int d0, e0;
      d0 = done_total;
      e0 = err_total;
      run_xfer(8'h00, 11, 1'b0, f, r);
      wait_end(200, d0, e0, ok);
      repeat (3) @(negedge clk); #1;
      n_checks++;
      if (!ok || f !== exp_frame(8'h00)) begin
         n_fail++;
         $display("FAIL nack_frame: got end=%0d frame=%b want 1 %b", ok, f, exp_frame(8'h00));
      end
      n_checks++;
      if (err_total - e0 !== 1 || done_total - d0 !== 0) begin
         n_fail++;
         $display("FAIL nack_pulses: got err=%0d done=%0d want 1 0",
                  err_total - e0, done_total - d0);
      end
      n_checks++;
      if (err_lines !== 2'b00 || ready_after_err !== 1'b1) begin
         n_fail++;
         $display("FAIL nack_release: got lines=%b ready_next=%b want 00 1",
                  err_lines, ready_after_err);
      end
   endtask

   task automatic test_timeout();
      logic [10:0] f;
      bit r, ok;
      int d0, e0;
      d0 = done_total;
      e0 = err_total;
      run_xfer(8'($urandom), 4, 1'b1, f, r);
      wait_end(700, d0, e0, ok);
      repeat (2) @(negedge clk); #1;
      n_checks++;
      if (!ok || err_total - e0 !== 1 || done_total - d0 !== 0) begin
         n_fail++;
         $display("FAIL timeout_pulse: got end=%0d err=%0d done=%0d want 1 1 0",
                  ok, err_total - e0, done_total - d0);
      end
      n_checks++;
      if (err_cyc - rel_cyc !== int'(TMO)) begin
         n_fail++;
         $display("FAIL timeout_latency: got %0d cycles want %0d", err_cyc - rel_cyc, TMO);
      end
      n_checks++;
      if (err_lines !== 2'b00) begin
         n_fail++;
         $display("FAIL timeout_release: got lines=%b want 00", err_lines);
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] f;
      bit r;
      int d0, e0;
      d0 = done_total;
      e0 = err_total;
      run_xfer(8'h00, 5, 1'b1, f, r);
      @(posedge clk); #3;
      n_checks++;
      if (kbdclk_low !== 1'b0 || kbddat_low !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_pre: got clk=%b dat=%b busy=%b want 0 1 1",
                  kbdclk_low, kbddat_low, busy);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({kbdclk_low, kbddat_low, tx_ready, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midreset_release: got clk/dat/ready/busy=%b want 0000",
                  {kbdclk_low, kbddat_low, tx_ready, busy});
      end
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      repeat (30) @(negedge clk); #1;
      n_checks++;
      if (done_total !== d0 || err_total !== e0) begin
         n_fail++;
         $display("FAIL midreset_pulses: got done=%0d err=%0d new pulses want 0 0",
                  done_total - d0, err_total - e0);
      end
      test_send(8'hFF);
   endtask

   task automatic test_busy_ignore();
      logic [10:0] f;
      bit r, ok;
      int d0, e0, v0;
      d0 = done_total;
      e0 = err_total;
      v0 = ready_viol;
      fork
         run_xfer(8'hED, 11, 1'b1, f, r);
         begin
            repeat (60) @(posedge clk); #1;
            tx_data  = 8'hAA;
            tx_valid = 1'b1;
            @(posedge clk); #1;
            tx_valid = 1'b0;
         end
      join
      wait_end(200, d0, e0, ok);
      repeat (60) @(negedge clk); #1;
      n_checks++;
      if (!ok || f !== exp_frame(8'hED)) begin
         n_fail++;
         $display("FAIL ignore_frame: got end=%0d frame=%b want 1 %b", ok, f, exp_frame(8'hED));
      end
      n_checks++;
      if (done_total - d0 !== 1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ignore_noqueue: got done=%0d busy=%b ready=%b want 1 0 1",
                  done_total - d0, busy, tx_ready);
      end
      n_checks++;
      if (ready_viol - v0 !== 0) begin
         n_fail++;
         $display("FAIL ignore_ready: got %0d busy cycles with ready=1 want 0", ready_viol - v0);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] fa, fb;
      logic [7:0]  a, b;
      bit ra, rb, ok, seen;
      logic b1, b2;
      int d0, e0;
      a  = 8'($urandom);
      b  = 8'($urandom);
      d0 = done_total;
      e0 = err_total;
      seen = 1'b0;
      b1 = 1'bx;
      b2 = 1'bx;
      fork
         begin
            device(11, 1'b1, fa, ra);
            device(11, 1'b1, fb, rb);
         end
         begin
            @(posedge clk); #1;
            tx_data  = a;
            tx_valid = 1'b1;
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               if (tx_ready) break;
            end
            @(posedge clk); #1;
            tx_data = b;
            for (int i = 0; i < 1000; i++) begin
               @(negedge clk); #1;
               if (done_total != d0) begin
                  seen = 1'b1;
                  break;
               end
            end
            repeat (2) @(negedge clk); #1;
            b1 = busy_after_done;
            b2 = busy_after_done2;
            tx_valid = 1'b0;
         end
      join
      wait_end(200, d0 + 1, e0, ok);
      repeat (3) @(negedge clk); #1;
      n_checks++;
      if (!seen || !ok || fa !== exp_frame(a) || fb !== exp_frame(b)) begin
         n_fail++;
         $display("FAIL b2b_frames: got %b %b want %b %b (seen=%0d end=%0d)",
                  fa, fb, exp_frame(a), exp_frame(b), seen, ok);
      end
      n_checks++;
      if (done_total - d0 !== 2 || err_total - e0 !== 0) begin
         n_fail++;
         $display("FAIL b2b_pulses: got done=%0d err=%0d want 2 0",
                  done_total - d0, err_total - e0);
      end
      n_checks++;
      if (b1 !== 1'b0 || b2 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_restart: got busy at done+1=%b done+2=%b want 0 1", b1, b2);
      end
   endtask

   initial begin
      test_reset();
      test_send(8'hED);
      test_send(8'hF4);
      test_nack();
      test_timeout();
      test_reset_mid();
      test_busy_ignore();
      for (int i = 0; i < 4; i++) begin
         test_send(8'($urandom));
      end
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
